// File: rtl/dcache_pkg.sv
// Shared encodings, geometry and FSM states for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 25;
  localparam int LINE_W   = 128;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FETCH,
    S_REFILL
  } state_e;
endpackage

// File: rtl/dcache_if.sv
// CPU data port plus block-wide main-memory port of the data cache.
// Handshake: CPU holds read/write/address/writedata stable while busywait=1; the cache holds
// mem_read/mem_write/mem_address/mem_writedata stable until an edge with mem_busywait=0 completes them.
interface dcache_if;
  logic [3:0]   read;
  logic [2:0]   write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_load_format.sv
// Picks the addressed word and byte/half lane out of a 128-bit line and extends it per load funct3.
module dcache_load_format
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0]   line,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [2:0]          funct3,
  output logic [31:0]         data
);
  logic [31:0] word;
  logic [15:0] half;
  logic [7:0]  lane_b;

  always_comb begin
    word   = line[{offset[3:2], 5'b0} +: 32];
    half   = word[{offset[1], 4'b0} +: 16];
    lane_b = word[{offset[1:0], 3'b0} +: 8];
    case (funct3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  data = {24'b0, lane_b};
      F3_LH:   data = {{16{half[15]}}, half};
      F3_LHU:  data = {16'b0, half};
      default: data = word;
    endcase
  end
endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache; stalls the CPU with busywait on misses.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic   clock,
  input  logic   reset,
  dcache_if.slave bus,
  output state_e dbg_state
);
  localparam int LINE_BITS = WORDS_PER_LINE * 32;

  state_e               state_q, state_d;
  logic                 valid_q [LINES];
  logic                 valid_d [LINES];
  logic                 dirty_q [LINES];
  logic                 dirty_d [LINES];
  logic [TAG_W-1:0]     tag_q   [LINES];
  logic [TAG_W-1:0]     tag_d   [LINES];
  logic [LINE_BITS-1:0] data_q  [LINES];
  logic [LINE_BITS-1:0] data_d  [LINES];
  logic [LINE_BITS-1:0] fill_q, fill_d;

  logic [INDEX_W-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic                 ld_req, st_req, hit;
  logic [LINE_BITS-1:0] cur_line, merged_line;
  logic [31:0]          load_word, old_word, new_word;

  assign idx       = bus.address[OFFSET_W +: INDEX_W];
  assign tag       = bus.address[31 -: TAG_W];
  assign ld_req    = bus.read[3];
  assign st_req    = bus.write[2];
  assign cur_line  = data_q[idx];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign dbg_state = state_q;

  dcache_load_format u_load (
    .line(cur_line), .offset(bus.address[3:0]), .funct3(bus.read[2:0]), .data(load_word)
  );

  // Same lane selector fetches the unextended word a store merges into.
  dcache_load_format u_store_word (
    .line(cur_line), .offset(bus.address[3:0]), .funct3(F3_LW), .data(old_word)
  );

  always_comb begin
    new_word = old_word;
    case (bus.write[1:0])
      F3_SB:   new_word[{bus.address[1:0], 3'b0} +: 8] = bus.writedata[7:0];
      F3_SH:   new_word[{bus.address[1], 4'b0} +: 16]  = bus.writedata[15:0];
      default: new_word = bus.writedata;
    endcase
    merged_line = cur_line;
    merged_line[{bus.address[3:2], 5'b0} +: 32] = new_word;
  end

  always_comb begin
    state_d           = state_q;
    valid_d           = valid_q;
    dirty_d           = dirty_q;
    tag_d             = tag_q;
    data_d            = data_q;
    fill_d            = fill_q;
    bus.busywait      = 1'b0;
    bus.readdata      = 32'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = bus.address[31:4];
    bus.mem_writedata = cur_line;
    case (state_q)
      S_IDLE: begin
        if (ld_req || st_req) begin
          if (hit) begin
            if (st_req) begin
              data_d[idx]  = merged_line;
              dirty_d[idx] = 1'b1;
            end else begin
              bus.readdata = load_word;
            end
          end else begin
            bus.busywait = 1'b1;
            state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        bus.busywait    = 1'b1;
        bus.mem_write   = 1'b1;
        bus.mem_address = {tag_q[idx], idx};
        if (!bus.mem_busywait) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.busywait = 1'b1;
        bus.mem_read = 1'b1;
        if (!bus.mem_busywait) begin
          fill_d  = bus.mem_readdata;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        bus.busywait = 1'b1;
        data_d[idx]  = fill_q;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        tag_d[idx]   = tag;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      for (int i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: byte-level architectural memory model, per-index tag model and a main-memory responder.
module tb_dcache;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_if bus();
  state_e dbg_state;

  dcache #(.LINES(8), .WORDS_PER_LINE(4)) dut (
    .clock(clk), .reset(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Main memory as seen by the responder, and what the CPU should observe architecturally.
  logic [127:0] main_mem [logic [27:0]];
  logic [127:0] arch     [logic [27:0]];
  logic         m_valid  [8];
  logic         m_dirty  [8];
  logic [24:0]  m_tag    [8];

  function automatic logic [127:0] init_line(input logic [27:0] la);
    logic [31:0] s;
    s = {la, 4'h5} * 32'h9E3779B1;
    return {s ^ 32'h13579BDF, s + 32'h2468ACE0, ~s, s};
  endfunction

  function automatic logic [127:0] main_get(input logic [27:0] la);
    return main_mem.exists(la) ? main_mem[la] : init_line(la);
  endfunction

  function automatic logic [127:0] arch_get(input logic [27:0] la);
    return arch.exists(la) ? arch[la] : init_line(la);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] f3);
    logic [127:0] ln;
    logic [7:0]   by;
    logic [15:0]  hw;
    logic [31:0]  w;
    int           b;
    ln = arch_get(a[31:4]);
    b  = int'(a[3:0]);
    by = ln[b*8 +: 8];
    hw = ln[(b/2)*16 +: 16];
    w  = ln[(b/4)*32 +: 32];
    case (f3)
      3'b000:  return {{24{by[7]}}, by};
      3'b100:  return {24'b0, by};
      3'b001:  return {{16{hw[15]}}, hw};
      3'b101:  return {16'b0, hw};
      default: return w;
    endcase
  endfunction

  task automatic store_arch(input logic [31:0] a, input logic [1:0] f3, input logic [31:0] wd);
    logic [127:0] ln;
    int           b;
    ln = arch_get(a[31:4]);
    b  = int'(a[3:0]);
    case (f3)
      2'b00:   ln[b*8 +: 8] = wd[7:0];
      2'b01:   ln[(b/2)*16 +: 16] = wd[15:0];
      default: ln[(b/4)*32 +: 32] = wd;
    endcase
    arch[a[31:4]] = ln;
  endtask

  // Memory responder: a request occupies lat cycles, mem_busywait high on all but the last.
  int lat_w = 1;
  int lat_f = 1;
  int mcnt  = 0;

  always @(negedge clk) begin
    bus.mem_readdata = main_get(bus.mem_address);
    if (bus.mem_write)     bus.mem_busywait = (mcnt < lat_w - 1);
    else if (bus.mem_read) bus.mem_busywait = (mcnt < lat_f - 1);
    else                   bus.mem_busywait = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) mcnt = 0;
    else if (bus.mem_read || bus.mem_write) begin
      if (!bus.mem_busywait) begin
        mcnt = 0;
        if (bus.mem_write) main_mem[bus.mem_address] = bus.mem_writedata;
      end else begin
        mcnt++;
      end
    end
  end

  typedef struct {
    logic         bw, mr, mw, chk_wd;
    logic [27:0]  maddr;
    logic [127:0] wd;
    logic [31:0]  rd;
  } exp_t;
  exp_t exp_q[$];

  function automatic exp_t mk(input logic bw, mr, mw, input logic [27:0] ma,
                              input logic cw, input logic [127:0] wd, input logic [31:0] rd);
    exp_t e;
    e.bw = bw; e.mr = mr; e.mw = mw; e.maddr = ma; e.chk_wd = cw; e.wd = wd; e.rd = rd;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busywait",  bus.busywait,  e.bw);
      chk("mem_read",  bus.mem_read,  e.mr);
      chk("mem_write", bus.mem_write, e.mw);
      chk("readdata",  bus.readdata,  e.rd);
      if (e.mr || e.mw) chk("mem_address", bus.mem_address, e.maddr);
      if (e.chk_wd) chk("mem_writedata", bus.mem_writedata, e.wd);
    end
  end

  typedef struct {
    logic [31:0]  rd;
    int           bw_cnt;
    logic [27:0]  fetch_addr;
    logic [27:0]  wb_addr;
    logic [127:0] wb_data;
  } obs_t;

  task automatic access(input logic ld, input logic st, input logic [2:0] lf3, input logic [1:0] sf3,
                        input logic [31:0] a, input logic [31:0] wd, input int lw, input int lf,
                        output obs_t o);
    int          idx;
    int          n;
    logic [24:0] tg;
    logic [27:0] vla;
    logic [31:0] rd_exp;
    idx = int'(a[6:4]);
    tg  = a[31:7];
    n   = 0;
    lat_w = lw;
    lat_f = lf;
    bus.read      = {ld, lf3};
    bus.write     = {st, sf3};
    bus.address   = a;
    bus.writedata = wd;
    if ((ld || st) && !(m_valid[idx] && m_tag[idx] == tg)) begin
      exp_q.push_back(mk(1, 0, 0, '0, 0, '0, '0)); n++;
      if (m_dirty[idx]) begin
        vla = {m_tag[idx], a[6:4]};
        repeat (lw) begin exp_q.push_back(mk(1, 0, 1, vla, 1, arch_get(vla), '0)); n++; end
      end
      repeat (lf) begin exp_q.push_back(mk(1, 1, 0, a[31:4], 0, '0, '0)); n++; end
      exp_q.push_back(mk(1, 0, 0, '0, 0, '0, '0)); n++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    rd_exp = (ld && !st) ? load_val(a, lf3) : 32'h0;
    exp_q.push_back(mk(0, 0, 0, '0, 0, '0, rd_exp)); n++;
    if (st) begin
      store_arch(a, sf3, wd);
      m_dirty[idx] = 1'b1;
    end
    o.rd = '0; o.bw_cnt = 0; o.fetch_addr = '0; o.wb_addr = '0; o.wb_data = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.busywait) o.bw_cnt++;
      if (bus.mem_read) o.fetch_addr = bus.mem_address;
      if (bus.mem_write) begin
        o.wb_addr = bus.mem_address;
        o.wb_data = bus.mem_writedata;
      end
      o.rd = bus.readdata;
    end
    @(posedge clk);
    #1;
    bus.read  = '0;
    bus.write = '0;
  endtask

  initial begin
    obs_t        o;
    logic [2:0]  lf3s [5];
    logic [31:0] a;
    int          op;
    logic        found;
    lf3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bus.read = '0; bus.write = '0; bus.address = '0; bus.writedata = '0;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busywait",  bus.busywait,  1'b0);
    chk("reset_mem_read",  bus.mem_read,  1'b0);
    chk("reset_mem_write", bus.mem_write, 1'b0);
    chk("reset_readdata",  bus.readdata,  32'h0);
    chk("reset_state",     dbg_state,     S_IDLE);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    main_mem[28'h4] = 128'hDDCCBBAA_0C0B0A09_88776655_44332211;
    arch[28'h4]     = 128'hDDCCBBAA_0C0B0A09_88776655_44332211;

    access(1, 0, F3_LW, 2'b00, 32'h40, 0, 1, 3, o);
    chk("lw40_data", o.rd, 32'h44332211);
    chk("lw40_stall", o.bw_cnt, 5);
    chk("lw40_fetch_addr", o.fetch_addr, 28'h4);
    access(1, 0, F3_LB, 2'b00, 32'h41, 0, 1, 1, o);
    chk("lb41", o.rd, 32'h00000022);
    chk("lb41_stall", o.bw_cnt, 0);
    access(1, 0, F3_LB, 2'b00, 32'h4F, 0, 1, 1, o);
    chk("lb4f", o.rd, 32'hFFFFFFDD);
    access(1, 0, F3_LBU, 2'b00, 32'h4F, 0, 1, 1, o);
    chk("lbu4f", o.rd, 32'h000000DD);
    access(1, 0, F3_LH, 2'b00, 32'h4E, 0, 1, 1, o);
    chk("lh4e", o.rd, 32'hFFFFDDCC);

    access(0, 1, 3'b000, F3_SW, 32'h44, 32'hCAFEBABE, 1, 1, o);
    chk("sw44_stall", o.bw_cnt, 0);
    access(1, 0, F3_LW, 2'b00, 32'h44, 0, 1, 1, o);
    chk("lw44", o.rd, 32'hCAFEBABE);

    access(1, 0, F3_LW, 2'b00, 32'hC4, 0, 2, 2, o);
    chk("wb_addr", o.wb_addr, 28'h4);
    chk("wb_word1", o.wb_data[63:32], 32'hCAFEBABE);
    chk("refetch_addr", o.fetch_addr, 28'hC);
    chk("dirty_miss_stall", o.bw_cnt, 6);

    access(1, 1, F3_LW, F3_SW, 32'hC8, 32'h12345678, 1, 1, o);
    chk("ld_st_readdata", o.rd, 32'h0);
    access(1, 0, F3_LW, 2'b00, 32'hC8, 0, 1, 1, o);
    chk("ld_after_st", o.rd, 32'h12345678);

    for (int t = 0; t < 400; t++) begin
      a = ($urandom_range(0, 3) << 7) | $urandom_range(0, 127);
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      op = $urandom_range(0, 9);
      access(op <= 3 || op == 8, op >= 4 && op <= 8, lf3s[$urandom_range(0, 4)],
             2'($urandom_range(0, 2)), a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4), o);
    end

    // Dirty line at index 5, then an abandoned miss: the store must be lost.
    access(0, 1, 3'b000, F3_SW, 32'h50, 32'hDEADBEEF, 1, 1, o);
    lat_w = 6;
    lat_f = 6;
    bus.read    = {1'b1, F3_LW};
    bus.address = 32'h1000_0040;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.mem_read) found = 1'b1;
    end
    chk("reach_fetch", found, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_state", dbg_state, S_IDLE);
    bus.read = '0;
    #1;
    chk("rst_busywait", bus.busywait, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (m_dirty[i]) arch[{m_tag[i], 3'(i)}] = main_get({m_tag[i], 3'(i)});
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(1, 0, F3_LW, 2'b00, 32'h40, 0, 1, 2, o);
    chk("post_reset_miss_stall", o.bw_cnt, 4);
    access(1, 0, F3_LW, 2'b00, 32'h50, 0, 1, 1, o);
    chk("dirty_lost", o.rd == 32'hDEADBEEF, 1'b0);

    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
